// File: rtl/morse_seq_buffer_if.sv
// Button/status bundle between the board-side driver and the Morse entry buffer.
//   dot/dash/enter/clear/back_btn : raw, unsynchronised buttons (driver -> buffer)
//   seq_out/len_out               : flattened committed slot patterns and symbol counts
//   char_pos_out                  : number of committed slots
//   cur_seq/cur_len               : in-progress character
//   commit_stb                    : one-cycle pulse when a slot is written
//   full/sym_ovf                  : slot store full / sticky symbol-dropped flag
interface morse_seq_buffer_if #(
  parameter int unsigned SYM_MAX    = 5,
  parameter int unsigned CHAR_SLOTS = 8
);
  localparam int unsigned CNT_W = $clog2(SYM_MAX + 1);
  localparam int unsigned POS_W = $clog2(CHAR_SLOTS + 1);

  logic                          dot_btn;
  logic                          dash_btn;
  logic                          enter_btn;
  logic                          clear_btn;
  logic                          back_btn;
  logic [CHAR_SLOTS*SYM_MAX-1:0] seq_out;
  logic [CHAR_SLOTS*CNT_W-1:0]   len_out;
  logic [POS_W-1:0]              char_pos_out;
  logic [SYM_MAX-1:0]            cur_seq;
  logic [CNT_W-1:0]              cur_len;
  logic                          commit_stb;
  logic                          full;
  logic                          sym_ovf;

  modport slave (
    input  dot_btn, dash_btn, enter_btn, clear_btn, back_btn,
    output seq_out, len_out, char_pos_out, cur_seq, cur_len, commit_stb, full, sym_ovf
  );

  modport master (
    output dot_btn, dash_btn, enter_btn, clear_btn, back_btn,
    input  seq_out, len_out, char_pos_out, cur_seq, cur_len, commit_stb, full, sym_ovf
  );
endinterface

// File: rtl/morse_seq_buffer.sv
// Morse entry buffer: conditions raw dot/dash/enter/clear/back buttons (2-flop sync +
// debounce + rising-edge detect) and assembles per-character symbol patterns
// (dot=0, dash=1, LSB = first symbol), committing them into CHAR_SLOTS slots.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : morse_seq_buffer_if slave side (raw buttons in, buffer state out)
module morse_seq_buffer #(
  parameter int unsigned SYM_MAX    = 5,
  parameter int unsigned CHAR_SLOTS = 8,
  parameter int unsigned DEB_CYC    = 16
) (
  input  logic                clk,
  input  logic                rst,
  morse_seq_buffer_if.slave   bus
);
  localparam int unsigned CNT_W = $clog2(SYM_MAX + 1);
  localparam int unsigned POS_W = $clog2(CHAR_SLOTS + 1);
  localparam int unsigned DEB_W = $clog2(DEB_CYC + 1);
  localparam int unsigned NBTN  = 5;
  localparam int unsigned B_DOT   = 0;
  localparam int unsigned B_DASH  = 1;
  localparam int unsigned B_ENTER = 2;
  localparam int unsigned B_CLEAR = 3;
  localparam int unsigned B_BACK  = 4;

  logic [NBTN-1:0]  raw_c;
  logic [NBTN-1:0]  sync1_q, sync2_q, lvl_q, prev_q;
  logic [DEB_W-1:0] deb_cnt_q [NBTN];
  logic [NBTN-1:0]  evt_c;

  assign raw_c = {bus.back_btn, bus.clear_btn, bus.enter_btn, bus.dash_btn, bus.dot_btn};

  // Synchroniser + debouncer: accepted level follows the synced value only after
  // DEB_CYC consecutive cycles of disagreement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q   <= '0;
      prev_q  <= '0;
      for (int unsigned i = 0; i < NBTN; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw_c;
      sync2_q <= sync1_q;
      prev_q  <= lvl_q;
      for (int unsigned i = 0; i < NBTN; i++) begin
        if (sync2_q[i] != lvl_q[i]) begin
          if (deb_cnt_q[i] == DEB_W'(DEB_CYC - 1)) begin
            lvl_q[i]     <= sync2_q[i];
            deb_cnt_q[i] <= '0;
          end else begin
            deb_cnt_q[i] <= deb_cnt_q[i] + DEB_W'(1);
          end
        end else begin
          deb_cnt_q[i] <= '0;
        end
      end
    end
  end

  // One-cycle event on each rising edge of the accepted level.
  assign evt_c = lvl_q & ~prev_q;

  logic [SYM_MAX-1:0] slot_seq_q [CHAR_SLOTS];
  logic [SYM_MAX-1:0] slot_seq_d [CHAR_SLOTS];
  logic [CNT_W-1:0]   slot_len_q [CHAR_SLOTS];
  logic [CNT_W-1:0]   slot_len_d [CHAR_SLOTS];
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [SYM_MAX-1:0] cur_seq_q, cur_seq_d;
  logic [CNT_W-1:0]   cur_len_q, cur_len_d;
  logic               ovf_q, ovf_d;
  logic               stb_q, stb_d;
  logic               full_c;

  assign full_c = (pos_q == POS_W'(CHAR_SLOTS));

  // Event handling, priority clear > back > enter > dot > dash.
  always_comb begin
    slot_seq_d = slot_seq_q;
    slot_len_d = slot_len_q;
    pos_d      = pos_q;
    cur_seq_d  = cur_seq_q;
    cur_len_d  = cur_len_q;
    ovf_d      = ovf_q;
    stb_d      = 1'b0;

    if (evt_c[B_CLEAR]) begin
      for (int unsigned k = 0; k < CHAR_SLOTS; k++) begin
        slot_seq_d[k] = '0;
        slot_len_d[k] = '0;
      end
      pos_d     = '0;
      cur_seq_d = '0;
      cur_len_d = '0;
      ovf_d     = 1'b0;
    end else if (evt_c[B_BACK]) begin
      ovf_d = 1'b0;
      if (cur_len_q != '0) begin
        // Clear the most recent symbol so unused bits stay zero.
        for (int unsigned b = 0; b < SYM_MAX; b++) begin
          if (CNT_W'(b) == cur_len_q - CNT_W'(1)) cur_seq_d[b] = 1'b0;
        end
        cur_len_d = cur_len_q - CNT_W'(1);
      end else if (pos_q != '0) begin
        for (int unsigned k = 0; k < CHAR_SLOTS; k++) begin
          if (POS_W'(k) == pos_q - POS_W'(1)) begin
            slot_seq_d[k] = '0;
            slot_len_d[k] = '0;
          end
        end
        pos_d = pos_q - POS_W'(1);
      end
    end else if (evt_c[B_ENTER]) begin
      // A full store keeps the in-progress character untouched.
      if (cur_len_q != '0 && !full_c) begin
        for (int unsigned k = 0; k < CHAR_SLOTS; k++) begin
          if (POS_W'(k) == pos_q) begin
            slot_seq_d[k] = cur_seq_q;
            slot_len_d[k] = cur_len_q;
          end
        end
        pos_d     = pos_q + POS_W'(1);
        cur_seq_d = '0;
        cur_len_d = '0;
        stb_d     = 1'b1;
      end
    end else if (evt_c[B_DOT] || evt_c[B_DASH]) begin
      if (cur_len_q == CNT_W'(SYM_MAX)) begin
        ovf_d = 1'b1;
      end else begin
        for (int unsigned b = 0; b < SYM_MAX; b++) begin
          if (CNT_W'(b) == cur_len_q) cur_seq_d[b] = !evt_c[B_DOT];
        end
        cur_len_d = cur_len_q + CNT_W'(1);
      end
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < CHAR_SLOTS; k++) begin
        slot_seq_q[k] <= '0;
        slot_len_q[k] <= '0;
      end
      pos_q     <= '0;
      cur_seq_q <= '0;
      cur_len_q <= '0;
      ovf_q     <= 1'b0;
      stb_q     <= 1'b0;
    end else begin
      slot_seq_q <= slot_seq_d;
      slot_len_q <= slot_len_d;
      pos_q      <= pos_d;
      cur_seq_q  <= cur_seq_d;
      cur_len_q  <= cur_len_d;
      ovf_q      <= ovf_d;
      stb_q      <= stb_d;
    end
  end

  logic [CHAR_SLOTS*SYM_MAX-1:0] seq_flat_c;
  logic [CHAR_SLOTS*CNT_W-1:0]   len_flat_c;

  // Flatten slot arrays onto the output buses.
  always_comb begin
    seq_flat_c = '0;
    len_flat_c = '0;
    for (int unsigned k = 0; k < CHAR_SLOTS; k++) begin
      seq_flat_c[k*SYM_MAX +: SYM_MAX] = slot_seq_q[k];
      len_flat_c[k*CNT_W +: CNT_W]     = slot_len_q[k];
    end
  end

  assign bus.seq_out      = seq_flat_c;
  assign bus.len_out      = len_flat_c;
  assign bus.char_pos_out = pos_q;
  assign bus.cur_seq      = cur_seq_q;
  assign bus.cur_len      = cur_len_q;
  assign bus.commit_stb   = stb_q;
  assign bus.full         = full_c;
  assign bus.sym_ovf      = ovf_q;
endmodule
